// File: rtl/trace_chain_checker.sv
// Trace continuity checker: each step's input state must match the previous step's predicted state.
// Optional build macro CHAIN_CONTINUE_ON_ERR_EN keeps checking past the first mismatch instead of halting.
module trace_chain_checker #(
    parameter int                  NUM_REGS     = 10,
    parameter int                  REG_W        = 32,
    parameter int                  CNT_W        = 16,
    parameter logic [NUM_REGS-1:0] CMP_MASK     = 10'h3FF,
    parameter logic [NUM_REGS-1:0] SYSCALL_MASK = 10'h3F8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_REGS*REG_W-1:0]     in_regs,
    input  logic [NUM_REGS*REG_W-1:0]     in_pred,
    input  logic [7:0]                    in_syscall_state,
    input  logic                          in_last,
    output logic                          done,
    output logic                          ok,
    output logic                          err,
    output logic [CNT_W-1:0]              err_step,
    output logic [$clog2(NUM_REGS)-1:0]   err_reg,
    output logic [CNT_W-1:0]              step_count,
    output logic [CNT_W-1:0]              err_count
);

    localparam int              IDX_W   = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHAIN = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_REGS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    state_t                       state_r, state_nxt_s;
    logic [NUM_REGS*REG_W-1:0]    pred_r;
    logic                         sys_flag_r;
    logic                         in_ready_r, done_r, ok_r, err_r;
    logic [CNT_W-1:0]             err_step_r, step_count_r, err_count_r;
    logic [IDX_W-1:0]             err_reg_r;

    logic                         accept_s, mismatch_s;
    logic [NUM_REGS-1:0]          neq_s, mask_s, masked_s;
    logic                         ready_nxt_s, done_nxt_s, ok_nxt_s, err_nxt_s;

    assign accept_s = in_valid & in_ready_r;

    // Masked register-by-register comparison against the stored prediction
    always_comb begin
        neq_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            neq_s[i] = (in_regs[i*REG_W +: REG_W] != pred_r[i*REG_W +: REG_W]);
        end
        if (sys_flag_r) begin
            mask_s = SYSCALL_MASK;
        end else begin
            mask_s = CMP_MASK;
        end
        masked_s   = neq_s & mask_s;
        mismatch_s = accept_s && (state_r == ST_CHAIN) && (|masked_s);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = in_last ? ST_DONE : ST_CHAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHAIN: begin
                if (accept_s && in_last) begin
                    state_nxt_s = ST_DONE;
                end else if (mismatch_s) begin
`ifdef CHAIN_CONTINUE_ON_ERR_EN
                    state_nxt_s = ST_CHAIN;
`else
                    state_nxt_s = ST_ERROR;
`endif
                end else begin
                    state_nxt_s = ST_CHAIN;
                end
            end
            ST_DONE:  state_nxt_s = ST_DONE;
            ST_ERROR: state_nxt_s = ST_ERROR;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state, registered below
    always_comb begin
        ready_nxt_s = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_CHAIN);
        done_nxt_s  = (state_nxt_s == ST_DONE);
        err_nxt_s   = err_r | mismatch_s;
        ok_nxt_s    = done_nxt_s & ~err_nxt_s;
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b1;
            done_r     <= 1'b0;
            ok_r       <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            in_ready_r <= ready_nxt_s;
            done_r     <= done_nxt_s;
            ok_r       <= ok_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

    // Stored prediction, counters and first-error capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_r       <= {(NUM_REGS*REG_W){1'b0}};
            sys_flag_r   <= 1'b0;
            step_count_r <= {CNT_W{1'b0}};
            err_count_r  <= {CNT_W{1'b0}};
            err_step_r   <= {CNT_W{1'b0}};
            err_reg_r    <= {IDX_W{1'b0}};
        end else begin
            if (accept_s) begin
                pred_r     <= in_pred;
                sys_flag_r <= |in_syscall_state;
                if (state_r == ST_IDLE) begin
                    step_count_r <= CNT_W'(1);
                end else if (step_count_r != CNT_MAX) begin
                    step_count_r <= step_count_r + CNT_W'(1);
                end
            end
            if (mismatch_s) begin
                // Only the first offending step is recorded
                if (!err_r) begin
                    err_step_r <= step_count_r;
                    err_reg_r  <= lowest_set(masked_s);
                end
                if (err_count_r != CNT_MAX) begin
                    err_count_r <= err_count_r + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign done       = done_r;
    assign ok         = ok_r;
    assign err        = err_r;
    assign err_step   = err_step_r;
    assign err_reg    = err_reg_r;
    assign step_count = step_count_r;
    assign err_count  = err_count_r;

endmodule

// File: tb/tb_trace_chain_checker.sv
// Self-checking bench for trace_chain_checker: directed scenarios plus randomized traces
// checked against a trace-level reference model.
module tb_trace_chain_checker;

    localparam int          NR   = 10;
    localparam int          RW   = 32;
    localparam int          CW   = 16;
    localparam int          VW   = NR * RW;
    localparam logic [9:0]  CMPM = 10'h3FF;
    localparam logic [9:0]  SYSM = 10'h3F8;
`ifdef CHAIN_CONTINUE_ON_ERR_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_regs;
    logic [VW-1:0] in_pred;
    logic [7:0]    in_syscall_state;
    logic          in_last;
    logic          done, ok, err;
    logic [CW-1:0] err_step, step_count, err_count;
    logic [3:0]    err_reg;

    int tests = 0;
    int fails = 0;

    trace_chain_checker dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_regs          (in_regs),
        .in_pred          (in_pred),
        .in_syscall_state (in_syscall_state),
        .in_last          (in_last),
        .done             (done),
        .ok               (ok),
        .err              (err),
        .err_step         (err_step),
        .err_reg          (err_reg),
        .step_count       (step_count),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;

    // Reference model: the trace seen so far, summarised
    logic [31:0] m_pred [NR];
    bit          m_flag, m_started, m_done, m_halt, m_err;
    int          m_cnt, m_ecnt, m_estep, m_ereg;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_pred[i] = 32'h0;
        m_flag = 0; m_started = 0; m_done = 0; m_halt = 0; m_err = 0;
        m_cnt = 0; m_ecnt = 0; m_estep = 0; m_ereg = 0;
    endtask

    function automatic bit exp_ready();
        return !(m_done || m_halt);
    endfunction

    task automatic model_accept(input logic [VW-1:0] regs, input logic [VW-1:0] pred,
                                input logic [7:0] sys, input logic last);
        int low;
        low = -1;
        if (!m_started) begin
            m_started = 1;
            m_cnt = 1;
            m_done = last;
        end else begin
            for (int i = NR - 1; i >= 0; i--) begin
                if ((m_flag ? SYSM[i] : CMPM[i]) && (regs[i*RW +: RW] !== m_pred[i])) low = i;
            end
            if (low >= 0) begin
                if (!m_err) begin
                    m_err = 1; m_estep = m_cnt; m_ereg = low;
                end
                if (m_ecnt < 65535) m_ecnt++;
            end
            if (m_cnt < 65535) m_cnt++;
            if (last) m_done = 1;
            else if (low >= 0 && !FEAT) m_halt = 1;
        end
        for (int i = 0; i < NR; i++) m_pred[i] = pred[i*RW +: RW];
        m_flag = (sys != 8'd0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        assert (act === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"},   32'(in_ready),   32'(exp_ready()));
        chk({tag, ".done"},       32'(done),       32'(m_done));
        chk({tag, ".ok"},         32'(ok),         32'(m_done && !m_err));
        chk({tag, ".err"},        32'(err),        32'(m_err));
        chk({tag, ".err_step"},   32'(err_step),   32'(m_estep));
        chk({tag, ".err_reg"},    32'(err_reg),    32'(m_ereg));
        chk({tag, ".step_count"}, 32'(step_count), 32'(m_cnt));
        chk({tag, ".err_count"},  32'(err_count),  32'(m_ecnt));
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*RW +: RW] = $urandom();
        return v;
    endfunction

    // Next step's input state: previous prediction, optionally with one register disturbed
    function automatic logic [VW-1:0] chain_regs(input int flip, input logic [31:0] x);
        logic [VW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*RW +: RW] = m_pred[i] ^ ((i == flip) ? x : 32'h0);
        return v;
    endfunction

    task automatic send(input string tag, input logic [VW-1:0] regs, input logic [VW-1:0] pred,
                        input logic [7:0] sys, input logic last);
        in_regs = regs; in_pred = pred; in_syscall_state = sys; in_last = last; in_valid = 1'b1;
        chk({tag, ".ready_pre"}, 32'(in_ready), 32'(exp_ready()));
        @(posedge clk);
        if (exp_ready()) model_accept(regs, pred, sys, last);
        #1;
        in_valid = 1'b0;
        check_all(tag);
    endtask

    // Asynchronous reset pulse away from the clock edge; in_valid is left as the caller set it
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int len;
        logic [VW-1:0] regs;
        rst_n = 1'b1; in_valid = 1'b0; in_regs = '0; in_pred = '0;
        in_syscall_state = 8'd0; in_last = 1'b0;
        model_reset();
        #2;
        do_reset("reset");
        chk("reset.ready_const", 32'(in_ready), 32'd1);

        // Three consistent steps
        send("cons0", rand_vec(), rand_vec(), 8'd0, 1'b0);
        send("cons1", chain_regs(-1, 32'h0), rand_vec(), 8'd0, 1'b0);
        send("cons2", chain_regs(-1, 32'h0), rand_vec(), 8'd0, 1'b1);
        chk("cons.count_const", 32'(step_count), 32'd3);
        chk("cons.ok_const", 32'(ok), 32'd1);
        send("cons_after", rand_vec(), rand_vec(), 8'd0, 1'b0);

        // eip break on step 1
        do_reset("rst_eip");
        send("eip0", rand_vec(), rand_vec(), 8'd0, 1'b0);
        send("eip1", chain_regs(8, 32'h4), rand_vec(), 8'd0, 1'b0);
        chk("eip.err_step_const", 32'(err_step), 32'd1);
        chk("eip.err_reg_const", 32'(err_reg), 32'd8);
        chk("eip.ready_const", 32'(in_ready), FEAT ? 32'd1 : 32'd0);
        send("eip2", chain_regs(-1, 32'h0), rand_vec(), 8'd0, 1'b1);

        // eax relaxed after a syscall step
        do_reset("rst_sys");
        send("sys0", rand_vec(), rand_vec(), 8'd1, 1'b0);
        send("sys1", chain_regs(0, 32'h55), rand_vec(), 8'd0, 1'b1);
        chk("sys.err_const", 32'(err), 32'd0);

        // Same eax difference without a syscall
        do_reset("rst_nosys");
        send("nosys0", rand_vec(), rand_vec(), 8'd0, 1'b0);
        send("nosys1", chain_regs(0, 32'h55), rand_vec(), 8'd0, 1'b1);
        chk("nosys.err_reg_const", 32'(err_reg), 32'd0);
        chk("nosys.ok_const", 32'(ok), 32'd0);

        // Six-step trace with mismatches on steps 2 and 4
        do_reset("rst_six");
        for (int s = 0; s < 6; s++) begin
            regs = (s == 0) ? rand_vec() : chain_regs((s == 2) ? 3 : ((s == 4) ? 5 : -1), 32'h100);
            send("six", regs, rand_vec(), 8'd0, (s == 5));
        end
        chk("six.err_step_const", 32'(err_step), 32'd2);
        chk("six.err_count_const", 32'(err_count), FEAT ? 32'd2 : 32'd1);
        chk("six.step_count_const", 32'(step_count), FEAT ? 32'd6 : 32'd3);
        chk("six.done_const", 32'(done), FEAT ? 32'd1 : 32'd0);

        // Reset mid-trace with in_valid held high
        do_reset("rst_mid");
        send("mid0", rand_vec(), rand_vec(), 8'd0, 1'b0);
        send("mid1", chain_regs(-1, 32'h0), rand_vec(), 8'd0, 1'b0);
        in_regs = rand_vec(); in_valid = 1'b1;
        do_reset("mid_rst");
        chk("mid.count_zero_const", 32'(step_count), 32'd0);
        send("mid2", chain_regs(2, 32'hFFFF), rand_vec(), 8'd0, 1'b0);
        send("mid3", chain_regs(-1, 32'h0), rand_vec(), 8'd0, 1'b1);
        chk("mid.ok_const", 32'(ok), 32'd1);

        // Single-step trace
        do_reset("rst_single");
        send("single", rand_vec(), rand_vec(), 8'd7, 1'b1);
        chk("single.ready_const", 32'(in_ready), 32'd0);
        send("single_after", rand_vec(), rand_vec(), 8'd0, 1'b0);

        // Randomized traces
        for (int t = 0; t < 40; t++) begin
            do_reset("rnd_rst");
            len = $urandom_range(1, 8);
            for (int s = 0; s < len; s++) begin
                if (s == 0) regs = rand_vec();
                else if ($urandom_range(0, 9) < 3) regs = chain_regs($urandom_range(0, NR - 1), $urandom() | 32'h1);
                else regs = chain_regs(-1, 32'h0);
                send("rnd", regs, rand_vec(),
                     ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
                     (s == len - 1));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
